power_mode_ctrl: RTL and testbench

Front-end vehicle power and mode controller. It sits directly upstream of the top-level drive-mode mux and feeds it; its outputs replace the ad-hoc power debounce and mode decode in that mux.
- Inputs: raw power_on/power_off buttons, the 3-bit mode switch and the stall/change flag from the manual drive core.
- Outputs: a registered power state, one-hot mode enables and LED drives.
- Long-press power-up; immediate power-down; lockout until all buttons are released.

---
 rtl/power_mode_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_power_mode_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/power_mode_ctrl.sv
// Vehicle power/mode front end: debounced long-press power-up, immediate power-down, lockout until release.
// Optional IDLE_OFF_EN macro adds a tick-based auto-off timer while ON.
module power_mode_ctrl #(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned DEB_TICKS  = 20,
    parameter int unsigned HOLD_TICKS = 1000,
    parameter int unsigned IDLE_TICKS = 60000
) (
    input  logic       sys_clk_i,
    input  logic       rst_i,
    input  logic       power_on_i,
    input  logic       power_off_i,
    input  logic [2:0] mode_signal_i,
    input  logic       change_i,
    input  logic       activity_i,
    output logic       power_now_o,
    output logic       power_on_led_o,
    output logic [2:0] mode_led_o,
    output logic       manual_en_o,
    output logic       semi_en_o,
    output logic       auto_en_o,
    output logic       power_event_o
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    // state    | meaning
    // S_OFF    | unpowered, waiting for a debounced power_on
    // S_ARMING | power_on held, counting hold ticks
    // S_ON     | powered, mode enables live
    // S_LOCKOUT| powered down, waiting for all buttons released
    typedef enum logic [1:0] {S_OFF, S_ARMING, S_ON, S_LOCKOUT} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q;
    logic            tick;
    logic [4:0]      sync1_q, sync2_q;
    logic            on_db_q, off_db_q;
    logic [2:0]      mode_db_q;
    logic [DW-1:0]   on_cnt_q, off_cnt_q, mode_cnt_q;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            power_q, power_d, event_q, event_d;
    logic [2:0]      mode_q, mode_d;
    logic            idle_to;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            sync1_q    <= {mode_signal_i, power_off_i, power_on_i};
            sync2_q    <= sync1_q;
        end
    end

    // Each debouncer only moves on ticks; any sample equal to the accepted level restarts it.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            on_db_q    <= 1'b0;
            off_db_q   <= 1'b0;
            mode_db_q  <= '0;
            on_cnt_q   <= '0;
            off_cnt_q  <= '0;
            mode_cnt_q <= '0;
        end else if (tick) begin
            if (sync2_q[0] != on_db_q) begin
                if (on_cnt_q == DW'(DEB_TICKS - 1)) begin
                    on_db_q  <= sync2_q[0];
                    on_cnt_q <= '0;
                end else begin
                    on_cnt_q <= on_cnt_q + 1'b1;
                end
            end else begin
                on_cnt_q <= '0;
            end
            if (sync2_q[1] != off_db_q) begin
                if (off_cnt_q == DW'(DEB_TICKS - 1)) begin
                    off_db_q  <= sync2_q[1];
                    off_cnt_q <= '0;
                end else begin
                    off_cnt_q <= off_cnt_q + 1'b1;
                end
            end else begin
                off_cnt_q <= '0;
            end
            if (sync2_q[4:2] != mode_db_q) begin
                if (mode_cnt_q == DW'(DEB_TICKS - 1)) begin
                    mode_db_q  <= sync2_q[4:2];
                    mode_cnt_q <= '0;
                end else begin
                    mode_cnt_q <= mode_cnt_q + 1'b1;
                end
            end else begin
                mode_cnt_q <= '0;
            end
        end
    end

`ifdef IDLE_OFF_EN
    localparam int IW = $clog2(IDLE_TICKS + 1);
    logic [IW-1:0] idle_cnt_q;

    assign idle_to = tick && !activity_i && (idle_cnt_q == IW'(IDLE_TICKS - 1));

    always_ff @(posedge sys_clk_i) begin
        if (rst_i || state_q != S_ON || activity_i) begin
            idle_cnt_q <= '0;
        end else if (tick) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end
`else
    logic unused_activity;
    assign unused_activity = activity_i;
    assign idle_to         = 1'b0;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q    <= S_OFF;
            hold_cnt_q <= '0;
            power_q    <= 1'b0;
            event_q    <= 1'b0;
            mode_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            power_q    <= power_d;
            event_q    <= event_d;
            mode_q     <= mode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_OFF: begin
                if (!off_db_q && on_db_q) begin
                    state_d    = S_ARMING;
                    hold_cnt_d = '0;
                end
            end
            S_ARMING: begin
                if (off_db_q || !on_db_q) begin
                    state_d = S_OFF;
                end else if (tick) begin
                    if (hold_cnt_q == HW'(HOLD_TICKS - 1)) begin
                        state_d = S_ON;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            S_ON: begin
                if (off_db_q || change_i || idle_to) begin
                    state_d = S_LOCKOUT;
                end
            end
            S_LOCKOUT: begin
                if (!on_db_q && !off_db_q) begin
                    state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_comb begin
        power_d = (state_q == S_ON);
        event_d = (power_d != power_q);
        mode_d  = '0;
        if (power_q && (mode_db_q == 3'b001 || mode_db_q == 3'b010 || mode_db_q == 3'b100)) begin
            mode_d = mode_db_q;
        end
    end

    // Gating with power_q drops the enables in the same cycle power_now falls.
    assign power_now_o    = power_q;
    assign power_on_led_o = power_q;
    assign power_event_o  = event_q;
    assign mode_led_o     = mode_q & {3{power_q}};
    assign manual_en_o    = mode_led_o[0];
    assign semi_en_o      = mode_led_o[1];
    assign auto_en_o      = mode_led_o[2];

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Directed bench for power_mode_ctrl with small timing parameters; define IDLE_OFF_EN to cover auto-off.
module tb_power_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst, power_on, power_off, change, activity;
    logic [2:0] mode_signal;
    logic       power_now, power_on_led, manual_en, semi_en, auto_en, power_event;
    logic [2:0] mode_led;

    int total = 0, bad = 0;
    int ev_cnt = 0, rise_cnt = 0, viol = 0;
    logic pn_prev = 1'b0;
    int c, e0, r0;

    always #5 clk = ~clk;

    power_mode_ctrl #(
        .TICK_DIV(4), .DEB_TICKS(2), .HOLD_TICKS(5), .IDLE_TICKS(6)
    ) dut (
        .sys_clk_i(clk), .rst_i(rst), .power_on_i(power_on), .power_off_i(power_off),
        .mode_signal_i(mode_signal), .change_i(change), .activity_i(activity),
        .power_now_o(power_now), .power_on_led_o(power_on_led), .mode_led_o(mode_led),
        .manual_en_o(manual_en), .semi_en_o(semi_en), .auto_en_o(auto_en),
        .power_event_o(power_event)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pn(input logic lvl, input int maxc, output int cyc);
        cyc = 0;
        while (power_now !== lvl && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Runs 1 ns after each edge so the stimulus process always sees settled counts.
    always begin
        @(posedge clk);
        #1;
        if (power_event === 1'b1) ev_cnt++;
        if (power_now === 1'b1 && pn_prev !== 1'b1) rise_cnt++;
        pn_prev = power_now;
        if ((int'(manual_en) + int'(semi_en) + int'(auto_en)) > 1) viol++;
        if (power_now === 1'b0 && (manual_en | semi_en | auto_en) === 1'b1) viol++;
        if (power_on_led !== power_now) viol++;
    end

    initial begin
        rst = 1'b1; power_on = 1'b0; power_off = 1'b0; change = 1'b0;
        activity = 1'b1; mode_signal = 3'b001;
        step(3);
        chk("rst_power_now", power_now, 0);
        chk("rst_led", power_on_led, 0);
        chk("rst_mode_led", mode_led, 0);
        chk("rst_enables", {manual_en, semi_en, auto_en}, 0);
        chk("rst_event", power_event, 0);
        rst = 1'b0;
        step(20);

        // long press powers up
        e0 = ev_cnt;
        power_on = 1'b1;
        wait_pn(1'b1, 60, c);
        chk("t1_rise", power_now, 1);
        chk("t1_latency_in_28_40", (c >= 28 && c <= 40), 1);
        chk("t1_en_lags_power", manual_en, 0);
        step(1);
        chk("t1_manual_en", manual_en, 1);
        chk("t1_mode_led", mode_led, 3'b001);
        step(80 - c - 1);
        power_on = 1'b0;
        chk("t1_one_event", ev_cnt - e0, 1);
        chk("t1_one_rise", rise_cnt, 1);
        step(20);

        // both buttons in ON: off wins, lockout holds while power_on held
        e0 = ev_cnt;
        power_on = 1'b1; power_off = 1'b1;
        wait_pn(1'b0, 20, c);
        chk("t3_off", power_now, 0);
        chk("t3_enables_off", {manual_en, semi_en, auto_en}, 0);
        chk("t3_event", ev_cnt - e0, 1);
        r0 = rise_cnt;
        step(200);
        chk("t3_lockout_both", rise_cnt - r0, 0);
        power_off = 1'b0;
        step(40);
        chk("t3_lockout_on_held", rise_cnt - r0, 0);
        chk("t3_still_off", power_now, 0);
        power_on = 1'b0;
        step(20);
        power_on = 1'b1;
        wait_pn(1'b1, 60, c);
        chk("t3_rearm", power_now, 1);
        power_on = 1'b0;
        step(20);

        // change forces off
        e0 = ev_cnt;
        change = 1'b1;
        step(1);
        change = 1'b0;
        step(1);
        chk("t4_change_off", power_now, 0);
        chk("t4_change_event", ev_cnt - e0, 1);
        step(10);
        power_on = 1'b1;
        wait_pn(1'b1, 60, c);
        chk("t4_back_on", power_now, 1);
        power_on = 1'b0;
        step(20);

        // mode decode while ON
        mode_signal = 3'b011;
        step(16);
        chk("t4_invalid_en", {manual_en, semi_en, auto_en}, 0);
        chk("t4_invalid_led", mode_led, 0);
        chk("t4_invalid_stays_on", power_now, 1);
        mode_signal = 3'b001;
        step(16);
        chk("t4_manual_again", manual_en, 1);
        mode_signal = 3'b010;
        c = 0;
        while (manual_en === 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("t4_manual_drop", manual_en, 0);
        chk("t4_semi_same_cycle", semi_en, 1);
        chk("t4_semi_led", mode_led, 3'b010);
        power_off = 1'b1;
        step(16);
        chk("t4_power_off", power_now, 0);
        power_off = 1'b0;
        step(20);

        // short press aborts arming
        e0 = ev_cnt; r0 = rise_cnt;
        power_on = 1'b1;
        step(12);
        power_on = 1'b0;
        step(40);
        chk("t2_short_off", power_now, 0);
        chk("t2_short_no_event", ev_cnt - e0, 0);

        // bounce never accepted: high 1 cycle in every 3
        for (int i = 0; i < 40; i++) begin
            power_on = (i % 3 == 0);
            step(1);
        end
        power_on = 1'b0;
        step(20);
        chk("t5_bounce_no_rise", rise_cnt - r0, 0);
        chk("t5_bounce_no_event", ev_cnt - e0, 0);

        // reset mid-ARMING then mid-ON
        power_on = 1'b1;
        step(14);
        rst = 1'b1;
        step(1);
        chk("t5_rst_arming", power_now, 0);
        rst = 1'b0;
        wait_pn(1'b1, 60, c);
        chk("t5_after_rst_on", power_now, 1);
        chk("t5_after_rst_latency", (c >= 28 && c <= 40), 1);
        step(5);
        e0 = ev_cnt;
        rst = 1'b1; power_on = 1'b0;
        step(1);
        chk("t5_rst_on_off", power_now, 0);
        rst = 1'b0;
        step(30);
        chk("t5_rst_no_event", ev_cnt - e0, 0);
        chk("t5_rst_stays_off", power_now, 0);

`ifdef IDLE_OFF_EN
        activity = 1'b0;
        power_on = 1'b1;
        wait_pn(1'b1, 60, c);
        power_on = 1'b0;
        wait_pn(1'b0, 40, c);
        chk("t6_idle_off", power_now, 0);
        chk("t6_idle_window", (c >= 18 && c <= 26), 1);
        step(20);
        power_on = 1'b1;
        wait_pn(1'b1, 60, c);
        power_on = 1'b0;
        chk("t6_on_again", power_now, 1);
        r0 = rise_cnt;
        for (int i = 0; i < 12; i++) begin
            activity = 1'b1;
            step(1);
            activity = 1'b0;
            step(11);
        end
        chk("t6_activity_keeps_on", power_now, 1);
        chk("t6_no_retrigger", rise_cnt - r0, 0);
        activity = 1'b1;
`endif

        chk("excl_enables_and_led", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
